// File: rtl/vedic_mul_seq.sv
// Sequential Vedic multiplier for the RV32IM M-extension: one H x H Vedic core is
// reused over four cycles and its shifted partial products are summed into a 2N-bit accumulator.

module vedic_core #(
    parameter int W = 16
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);

    generate
        if (W >= 4 && (W % 2) == 0) begin : g_split
            localparam int L = W / 2;

            logic [W-1:0] ll;
            logic [W-1:0] hl;
            logic [W-1:0] lh;
            logic [W-1:0] hh;

            vedic_core #(.W(L)) u_ll (.x(x[L-1:0]), .y(y[L-1:0]), .p(ll));
            vedic_core #(.W(L)) u_hl (.x(x[W-1:L]), .y(y[L-1:0]), .p(hl));
            vedic_core #(.W(L)) u_lh (.x(x[L-1:0]), .y(y[W-1:L]), .p(lh));
            vedic_core #(.W(L)) u_hh (.x(x[W-1:L]), .y(y[W-1:L]), .p(hh));

            // The cross products share the same weight, so they are added at one offset.
            assign p = {hh, ll}
                     + {{L{1'b0}}, hl, {L{1'b0}}}
                     + {{L{1'b0}}, lh, {L{1'b0}}};
        end else begin : g_urdhva
            localparam int CW = $clog2(W) + 2;

            // Urdhva-tiryagbhyam leaf: column-wise crosswise sums with a rippling carry.
            always_comb begin
                logic [CW-1:0] col;
                logic [CW-1:0] carry;
                p     = '0;
                col   = '0;
                carry = '0;
                for (int k = 0; k < 2 * W; k++) begin
                    col = carry;
                    for (int i = 0; i < W; i++) begin
                        for (int j = 0; j < W; j++) begin
                            if (i + j == k) begin
                                col = col + CW'(x[i] & y[j]);
                            end
                        end
                    end
                    p[k]  = col[0];
                    carry = col >> 1;
                end
            end
        end
    endgenerate

endmodule

module vedic_mul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         kill,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int H = N / 2;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3,
        FIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [1:0]     op_q;
    logic           neg_q;
    logic [2*N-1:0] acc;

    logic           sign_a;
    logic           sign_b;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic           accept;
    logic           zero_op;

    logic [H-1:0]   sub_a;
    logic [H-1:0]   sub_b;
    logic [N-1:0]   sub_p;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] prod_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Magnitude in N unsigned bits: the most negative value maps exactly to 2^(N-1).
    assign sign_a  = a[N-1] & ((op == 2'b01) | (op == 2'b10));
    assign sign_b  = b[N-1] & (op == 2'b01);
    assign abs_a   = sign_a ? -a : a;
    assign abs_b   = sign_b ? -b : b;
    assign accept  = in_valid & in_ready & ~kill;
    assign zero_op = (abs_a == '0) | (abs_b == '0);

    vedic_core #(.W(H)) u_core (
        .x (sub_a),
        .y (sub_b),
        .p (sub_p)
    );

    always_comb begin
        sub_a  = mag_a[H-1:0];
        sub_b  = mag_b[H-1:0];
        addend = {{N{1'b0}}, sub_p};
        case (state)
            P1: begin
                sub_a  = mag_a[N-1:H];
                addend = {{H{1'b0}}, sub_p, {H{1'b0}}};
            end
            P2: begin
                sub_b  = mag_b[N-1:H];
                addend = {{H{1'b0}}, sub_p, {H{1'b0}}};
            end
            P3: begin
                sub_a  = mag_a[N-1:H];
                sub_b  = mag_b[N-1:H];
                addend = {sub_p, {N{1'b0}}};
            end
            default: ;
        endcase
    end

    assign prod_fin = neg_q ? -acc : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A flush wins over both the handshake and the normal sequence advance.
    always_comb begin
        state_nx = state;
        if (kill && state != IDLE) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = zero_op ? DONE : P0;
                P0:      state_nx = P1;
                P1:      state_nx = P2;
                P2:      state_nx = P3;
                P3:      state_nx = FIN;
                FIN:     state_nx = DONE;
                DONE:    if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a  <= '0;
            mag_b  <= '0;
            op_q   <= 2'b00;
            neg_q  <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        op_q  <= op;
                        neg_q <= sign_a ^ sign_b;
                        acc   <= '0;
                        if (zero_op) begin
                            result <= '0;
                        end
                    end
                end
                P0, P1, P2, P3: begin
                    if (!kill) begin
                        acc <= acc + addend;
                    end
                end
                FIN: begin
                    if (!kill) begin
                        result <= (op_q == 2'b00) ? prod_fin[N-1:0] : prod_fin[2*N-1:N];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
